// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus-side types for the arvi hart: arbiter state encoding, word byte-enable
// constant and the request bundle used by bus clients.
package arvi_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IC = 2'd1,
    ARB_GNT_DM = 2'd2
  } arb_state_e;

  localparam logic [3:0]  BE_WORD  = 4'hF;
  localparam int unsigned BUS_XLEN = 32;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wdata;
    logic [3:0]          byte_en;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// Per-transaction wait counter: expires in the TIMEOUT-th enabled cycle after a clear.
// TIMEOUT=0 never expires.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds prior waiting cycles, so the current cycle is the TIMEOUT-th at LAST.
  assign o_expired = (TIMEOUT != 0) && i_enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the i-cache refill port and the
// data port, with atomic bus-lock and per-transaction timeout.
module mem_bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic [XLEN-1:0] o_IC_Data,
  output logic            o_IC_MemReady,
  input  logic            i_DM_MemRead,
  input  logic            i_DM_Wen,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [3:0]      i_DM_byte_en,
  input  logic            i_DM_atomic,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic            o_BUS_req,
  output logic            o_BUS_we,
  output logic [XLEN-1:0] o_BUS_addr,
  output logic [XLEN-1:0] o_BUS_wdata,
  output logic [3:0]      o_BUS_byte_en,
  input  logic [XLEN-1:0] i_BUS_rdata,
  input  logic            i_BUS_ack,
  output logic            o_bus_err
);

  arb_state_e state_q, state_d;
  logic       last_dm_q, last_dm_d;
  logic       lock_q, lock_d;
  logic       ic_pend, dm_pend, granted, expired;

  assign ic_pend = i_IC_DataReq;
  assign dm_pend = i_DM_MemRead | i_DM_Wen;
  assign granted = (state_q != ARB_IDLE);

  // Clearing throughout IDLE is equivalent to clearing on the grant edge.
  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!granted),
    .i_enable  (granted && !i_BUS_ack),
    .o_expired (expired)
  );

  always_comb begin
    state_d         = state_q;
    last_dm_d       = last_dm_q;
    lock_d          = lock_q;
    o_IC_Data       = '0;
    o_IC_MemReady   = 1'b0;
    o_DM_ReadData   = '0;
    o_DM_data_ready = 1'b0;
    o_BUS_req       = 1'b0;
    o_BUS_we        = 1'b0;
    o_BUS_addr      = '0;
    o_BUS_wdata     = '0;
    o_BUS_byte_en   = '0;
    o_bus_err       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (lock_q) begin
          if (dm_pend) state_d = ARB_GNT_DM;
        end else if (ic_pend && dm_pend) begin
          state_d = last_dm_q ? ARB_GNT_IC : ARB_GNT_DM;
        end else if (ic_pend) begin
          state_d = ARB_GNT_IC;
        end else if (dm_pend) begin
          state_d = ARB_GNT_DM;
        end
      end

      ARB_GNT_IC: begin
        o_BUS_req     = 1'b1;
        o_BUS_addr    = i_IC_Addr;
        o_BUS_byte_en = BE_WORD;
        if (i_BUS_ack) begin
          o_IC_MemReady = 1'b1;
          o_IC_Data     = i_BUS_rdata;
          last_dm_d     = 1'b0;
          state_d       = ARB_IDLE;
        end else if (expired) begin
          o_IC_MemReady = 1'b1;
          o_bus_err     = 1'b1;
          lock_d        = 1'b0;
          state_d       = ARB_IDLE;
        end
      end

      ARB_GNT_DM: begin
        o_BUS_req     = 1'b1;
        o_BUS_we      = i_DM_Wen;
        o_BUS_addr    = i_DM_Addr;
        o_BUS_wdata   = i_DM_Wd;
        o_BUS_byte_en = i_DM_byte_en;
        if (i_BUS_ack) begin
          o_DM_data_ready = 1'b1;
          o_DM_ReadData   = i_BUS_rdata;
          last_dm_d       = 1'b1;
          lock_d          = i_DM_atomic;
          state_d         = ARB_IDLE;
        end else if (expired) begin
          o_DM_data_ready = 1'b1;
          o_bus_err       = 1'b1;
          lock_d          = 1'b0;
          state_d         = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ARB_IDLE;
      last_dm_q <= 1'b1;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_dm_q <= last_dm_d;
      lock_q    <= lock_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed cycle table, async-reset sequence, then random
// traffic checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TO   = 4;
  localparam logic [31:0] T_IC_A = 32'h0000_0100;
  localparam logic [31:0] T_DM_A = 32'h0000_2004;
  localparam logic [31:0] T_WD   = 32'h0000_BEEF;
  localparam logic [3:0]  T_BE   = 4'b0011;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ic_req = 1'b0, dm_rd = 1'b0, dm_wen = 1'b0, dm_at = 1'b0, bus_ack = 1'b0;
  logic [XLEN-1:0] ic_addr = '0, dm_addr = '0, dm_wd = '0, bus_rdata = '0;
  logic [3:0]      dm_be = '0;
  logic [XLEN-1:0] ic_data, dm_rdata, bus_addr, bus_wdata;
  logic            ic_rdy, dm_rdy, bus_req, bus_we, bus_err;
  logic [3:0]      bus_be;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_IC_DataReq    (ic_req),
    .i_IC_Addr       (ic_addr),
    .o_IC_Data       (ic_data),
    .o_IC_MemReady   (ic_rdy),
    .i_DM_MemRead    (dm_rd),
    .i_DM_Wen        (dm_wen),
    .i_DM_Addr       (dm_addr),
    .i_DM_Wd         (dm_wd),
    .i_DM_byte_en    (dm_be),
    .i_DM_atomic     (dm_at),
    .o_DM_ReadData   (dm_rdata),
    .o_DM_data_ready (dm_rdy),
    .o_BUS_req       (bus_req),
    .o_BUS_we        (bus_we),
    .o_BUS_addr      (bus_addr),
    .o_BUS_wdata     (bus_wdata),
    .o_BUS_byte_en   (bus_be),
    .i_BUS_rdata     (bus_rdata),
    .i_BUS_ack       (bus_ack),
    .o_bus_err       (bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        icr;
    logic [31:0] icd;
    logic        dmr;
    logic [31:0] dmd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        ic, rd, wr, at, ack;
    logic [31:0] rdata;
    int          own;   // 0 bus idle, 1 IC owns bus, 2 DM owns bus
    int          rdy;   // 0 none, 1 IC ready, 2 DM ready
    logic [31:0] data;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input exp_t e, input string tag);
    chk({tag, ".req"},   32'(bus_req),   32'(e.req));
    chk({tag, ".we"},    32'(bus_we),    32'(e.we));
    chk({tag, ".addr"},  bus_addr,       e.addr);
    chk({tag, ".wdata"}, bus_wdata,      e.wdata);
    chk({tag, ".be"},    32'(bus_be),    32'(e.be));
    chk({tag, ".icrdy"}, 32'(ic_rdy),    32'(e.icr));
    chk({tag, ".icdat"}, ic_data,        e.icd);
    chk({tag, ".dmrdy"}, 32'(dm_rdy),    32'(e.dmr));
    chk({tag, ".dmdat"}, dm_rdata,       e.dmd);
    chk({tag, ".err"},   32'(bus_err),   32'(e.err));
  endtask

  function automatic vec_t v(input logic ic, input logic rd, input logic wr, input logic at,
                             input logic ack, input logic [31:0] rdata, input int own,
                             input int rdy, input logic [31:0] data, input logic err);
    vec_t r;
    r.ic = ic; r.rd = rd; r.wr = wr; r.at = at; r.ack = ack; r.rdata = rdata;
    r.own = own; r.rdy = rdy; r.data = data; r.err = err;
    return r;
  endfunction

  function automatic exp_t vec_expect(input vec_t t);
    exp_t e;
    e.req   = (t.own != 0);
    e.we    = (t.own == 2) && t.wr;
    e.addr  = (t.own == 1) ? T_IC_A : (t.own == 2) ? T_DM_A : 32'h0;
    e.wdata = (t.own == 2) ? T_WD : 32'h0;
    e.be    = (t.own == 1) ? 4'hF : (t.own == 2) ? T_BE : 4'h0;
    e.icr   = (t.rdy == 1);
    e.icd   = (t.rdy == 1) ? t.data : 32'h0;
    e.dmr   = (t.rdy == 2);
    e.dmd   = (t.rdy == 2) ? t.data : 32'h0;
    e.err   = t.err;
    return e;
  endfunction

  // Reference model: who holds the bus, how long it has waited, fairness and lock flags.
  int m_owner;
  int m_wait;
  bit m_last_dm;
  bit m_lock;

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_last_dm = 1'b1; m_lock = 1'b0;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    bit done, tmo;
    e = '{default: '0};
    if (m_owner == 1) begin
      e.req = 1'b1; e.addr = ic_addr; e.be = 4'hF;
    end else if (m_owner == 2) begin
      e.req = 1'b1; e.we = dm_wen; e.addr = dm_addr; e.wdata = dm_wd; e.be = dm_be;
    end
    done = (m_owner != 0) && bus_ack;
    tmo  = (m_owner != 0) && !bus_ack && (TO != 0) && (m_wait + 1 >= int'(TO));
    if (done || tmo) begin
      if (m_owner == 1) begin
        e.icr = 1'b1; e.icd = done ? bus_rdata : 32'h0;
      end else begin
        e.dmr = 1'b1; e.dmd = done ? bus_rdata : 32'h0;
      end
      e.err = tmo;
    end
    return e;
  endfunction

  task automatic model_advance();
    bit done, tmo, icp, dmp;
    done = (m_owner != 0) && bus_ack;
    tmo  = (m_owner != 0) && !bus_ack && (TO != 0) && (m_wait + 1 >= int'(TO));
    icp  = ic_req;
    dmp  = dm_rd || dm_wen;
    if (done) begin
      m_last_dm = (m_owner == 2);
      if (m_owner == 2) m_lock = dm_at;
      m_owner = 0;
    end else if (tmo) begin
      m_lock = 1'b0;
      m_owner = 0;
    end else if (m_owner != 0) begin
      m_wait++;
    end else begin
      m_wait = 0;
      if (m_lock)          m_owner = dmp ? 2 : 0;
      else if (icp && dmp) m_owner = m_last_dm ? 1 : 2;
      else                 m_owner = icp ? 1 : (dmp ? 2 : 0);
    end
  endtask

  vec_t tbl[$];
  exp_t zero_e;

  initial begin
    exp_t e;
    bit   prev_icr, prev_dmr;

    zero_e = '{default: '0};

    // Reset state: outputs stay 0 even with requests present.
    ic_req = 1'b1; dm_rd = 1'b1;
    #1 check_outs(zero_e, "reset0");
    repeat (2) @(posedge clk);
    #1 check_outs(zero_e, "reset1");
    ic_req = 1'b0; dm_rd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // B: tie after reset -> IC, idle cycle, DM
    tbl.push_back(v(1,1,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,1,0,0,1,32'h11,       1,1,32'h11,0));
    tbl.push_back(v(0,1,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(0,1,0,0,1,32'h22,       2,2,32'h22,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // A: IC read alone, ack 3 cycles after req
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'h5A5A,     1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'h0,        1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'h0,        1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,1,32'h13,       1,1,32'h13,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // C: tie after IC was served -> DM, then IC
    tbl.push_back(v(1,1,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,1,0,0,1,32'h33,       2,2,32'h33,0));
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,1,32'h44,       1,1,32'h44,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // D: DM write
    tbl.push_back(v(0,0,1,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(0,0,1,0,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(0,0,1,0,1,32'h55,       2,2,32'h55,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // E: atomic read locks out IC until non-atomic DM completes
    tbl.push_back(v(0,1,0,1,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,1,32'h66,       2,2,32'h66,0));
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,1,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,1,0,1,32'h77,       2,2,32'h77,0));
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,1,32'h88,       1,1,32'h88,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // F: IC timeout after 4 granted cycles
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'hDEADBEEF, 1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'hDEADBEEF, 1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'hDEADBEEF, 1,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,0,32'hDEADBEEF, 1,1,32'h0,1));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // G: ack on the 4th granted cycle wins over timeout
    tbl.push_back(v(0,1,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(0,1,0,0,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(0,1,0,0,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(0,1,0,0,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(0,1,0,0,1,32'h99,       2,2,32'h99,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // H: timeout of a locked DM access releases the lock
    tbl.push_back(v(0,1,0,1,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,1,32'hA1,       2,2,32'hA1,0));
    tbl.push_back(v(1,1,0,1,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,0,32'h0,        2,0,32'h0,0));
    tbl.push_back(v(1,1,0,1,0,32'h0,        2,2,32'h0,1));
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(1,0,0,0,1,32'hB2,       1,1,32'hB2,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));
    // I: request dropped while granted still completes
    tbl.push_back(v(1,0,0,0,0,32'h0,        0,0,32'h0,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        1,0,32'h0,0));
    tbl.push_back(v(0,0,0,0,1,32'hC3,       1,1,32'hC3,0));
    tbl.push_back(v(0,0,0,0,0,32'h0,        0,0,32'h0,0));

    ic_addr = T_IC_A; dm_addr = T_DM_A; dm_wd = T_WD; dm_be = T_BE;
    foreach (tbl[i]) begin
      ic_req = tbl[i].ic; dm_rd = tbl[i].rd; dm_wen = tbl[i].wr; dm_at = tbl[i].at;
      bus_ack = tbl[i].ack; bus_rdata = tbl[i].rdata;
      @(negedge clk);
      check_outs(vec_expect(tbl[i]), $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Async reset in the middle of a DM grant.
    dm_rd = 1'b1; dm_addr = 32'h3000; bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outs(zero_e, "rst_mid");
    ic_req = 1'b1; ic_addr = 32'h400;
    @(posedge clk); #1;
    check_outs(zero_e, "rst_hold");
    #1 rst_n = 1'b1;
    model_reset();
    dm_at = 1'b0; dm_wen = 1'b0; dm_wd = 32'h1234; dm_be = 4'hF;

    // Random traffic; requesters hold until their ready pulse, then drop.
    prev_icr = 1'b0; prev_dmr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1) begin
        chk("post_reset.ic_first_req",  32'(bus_req), 32'd1);
        chk("post_reset.ic_first_addr", bus_addr, 32'h400);
      end
      if (prev_icr) ic_req = 1'b0;
      else if (!ic_req && $urandom_range(0, 3) == 0) begin
        ic_req = 1'b1; ic_addr = $urandom() & 32'hFFFF_FFFC;
      end else if (ic_req && m_owner == 1 && $urandom_range(0, 19) == 0) ic_req = 1'b0;
      if (prev_dmr) begin
        dm_rd = 1'b0; dm_wen = 1'b0;
      end else if (!(dm_rd || dm_wen) && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) dm_rd = 1'b1; else dm_wen = 1'b1;
        dm_addr = $urandom(); dm_wd = $urandom(); dm_be = 4'($urandom_range(1, 15));
        dm_at = ($urandom_range(0, 3) == 0);
      end
      bus_ack   = (m_owner != 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 20);
      bus_rdata = $urandom();
      @(negedge clk);
      e = model_expect();
      check_outs(e, $sformatf("rnd%0d", cyc));
      model_advance();
      prev_icr = e.icr; prev_dmr = e.dmr;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares one external memory bus between the instruction-cache refill port and the data-memory port of a single-cycle RV32 hart. It sits between the datapath's `i_cache`/`d_mem` memory-side signals and the system bus. It provides round-robin fairness, a bus-lock for atomic read-modify-write sequences and a per-transaction timeout. Each transaction owns the bus from grant until acknowledge; there is no pipelining of outstanding requests.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `TIMEOUT`, 255, cycles a granted transaction may wait for `i_BUS_ack` before being aborted; 0 disables the timeout.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_IC_DataReq`  in  1  instruction refill request (level).
- `i_IC_Addr`  in  XLEN  refill address.
- `o_IC_Data`  out  XLEN  refill data.
- `o_IC_MemReady`  out  1  one-cycle completion pulse to the i-cache.
- `i_DM_MemRead`, `i_DM_Wen`  in  1  data read/write request (level; mutually exclusive).
- `i_DM_Addr`, `i_DM_Wd`  in  XLEN  data address and write data.
- `i_DM_byte_en`  in  4  byte lanes.
- `i_DM_atomic`  in  1  the current data access belongs to an atomic sequence.
- `o_DM_ReadData`  out  XLEN  data read result.
- `o_DM_data_ready`  out  1  one-cycle completion pulse to the data port.
- `o_BUS_req`, `o_BUS_we`  out  1  bus request and write strobe.
- `o_BUS_addr`, `o_BUS_wdata`  out  XLEN  bus address and write data.
- `o_BUS_byte_en`  out  4  bus byte lanes; `4'hF` for IC reads.
- `i_BUS_rdata`  in  XLEN  bus read data.
- `i_BUS_ack`  in  1  bus completion; sampled only while `o_BUS_req`=1.
- `o_bus_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, GNT_IC, GNT_DM. Registered: state, `last_dm` (last grant went to DM), `lock`, and a timeout counter of width `$clog2(TIMEOUT+1)`.
- IDLE: `o_BUS_req`=0. The pending set is IC=`i_IC_DataReq`, DM=`i_DM_MemRead|i_DM_Wen`.
  - If `lock`=1, only DM may be granted.
  - Else if both are pending, grant the one not last served: `last_dm`=1 grants IC.
  - Else grant the single pending port.
- GNT_x: bus outputs are muxed from port x (IC: `we`=0, `byte_en`=F). `o_BUS_req`=1 until ack or timeout.
- On `i_BUS_ack`:
  - Pulse x's ready for that same cycle, with `o_*Data` = `i_BUS_rdata`. Reads and writes both return data.
  - Update `last_dm`.
  - DM grant only: `lock` <= `i_DM_atomic`.
  - Go to IDLE.
- Ready and data outputs of the non-granted port are 0.
- Timeout: the counter clears on grant and increments each GNT cycle without ack. When it reaches `TIMEOUT`:
  - Pulse x's ready with data 0 and pulse `o_bus_err`.
  - Clear `lock` and go to IDLE.
  - Ack and timeout in the same cycle: ack wins, no error.
- A request dropped while granted does not cancel the transaction. The bus request holds until ack or timeout, and the ready pulse is still issued.
- `lock` clears only on a DM completion with `i_DM_atomic`=0, or on timeout.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, `last_dm`=1 (IC wins first tie), `lock`=0, counter 0.
- Every output is 0 during and after reset until the first grant.
- Reset mid-transaction drops `o_BUS_req` immediately; the response is lost and no ready pulse is issued.
- Latency:
  - Request seen in IDLE at cycle n → `o_BUS_req` at n+1.
  - Ack at cycle m → ready pulse at m (combinational) → IDLE at m+1.
  - Minimum 2 cycles per access, with 1 idle bus cycle between back-to-back grants.
- Ready pulses last exactly one cycle. Requesters must deassert or change their request in the cycle after ready.
- A requester held off by a tie waits at most one other transaction, except while `lock` is set.

## Structure
- Shared package `arvi_bus_pkg`: state enum (`ARB_IDLE`, `ARB_GNT_IC`, `ARB_GNT_DM`), the byte-enable constant `BE_WORD` = 4'hF, and the bus request struct used by future bus clients.
- One sub-module is natural: `arb_timeout_ctr` (clear, enable, expired; parameter `TIMEOUT`, with 0 meaning never expire).
- Everything else stays in a single module.

## Test plan
- IC read alone, address 0x100: ack 3 cycles after `o_BUS_req` with rdata 0x00000013. Expect `o_IC_MemReady` for one cycle with `o_IC_Data`=0x13, and DM outputs 0.
- IC and DM requested in the same cycle after reset: IC is granted first, then after 1 idle cycle DM is granted. A second simultaneous pair is served DM then IC.
- DM write to 0x2004, `byte_en`=4'b0011, wdata 0xBEEF: expect bus `we`=1, `byte_en`=3, `addr`=0x2004, and `o_DM_data_ready` on the ack cycle.
- Atomic: DM read with `i_DM_atomic`=1 completes while IC is pending. Expect IC not granted; the DM write with atomic=0 is granted next, then IC.
- `TIMEOUT`=4 with ack never asserted: after 4 GNT cycles expect `o_bus_err`, the ready pulse, data 0 and `o_BUS_req` falling. Ack on the 4th cycle gives no error.
- Async reset asserted mid-GNT_DM: `o_BUS_req` goes 0 without a clock edge. After release, an IC request is granted first.
